// File: rtl/fp_convert_arbiter.sv
// Round-robin arbiter sharing one double-to-float converter among NREQ requesters.
// One conversion in flight at a time; converter hangs are bounded by a timeout.
module fp_convert_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_double,
  input  logic [2*NREQ-1:0]    req_rounding,
  output logic                 cvt_rst_n,
  output logic [63:0]          cvt_double,
  output logic [1:0]           cvt_rounding,
  input  logic                 cvt_done,
  input  logic [31:0]          cvt_float,
  input  logic                 cvt_nan,
  input  logic                 cvt_ovf,
  input  logic                 cvt_unf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [31:0]          rsp_float,
  output logic [3:0]           rsp_flags,
  output logic [3:0]           sticky_flags,
  input  logic                 sticky_clr,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. req_ready never waits on anything but req_valid/rr_ptr; rsp_valid holds
  // its payload stable until rsp_ready is seen.

  state_t      state;
  logic [2:0]  rr_ptr;
  logic [7:0]  cnt;
  logic [NREQ-1:0] grant;
  logic [2:0]  gid;
  int          gid_i;
  logic        found;
  logic        accept;

  always_comb begin
    grant = '0;
    gid   = '0;
    gid_i = 0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gid        = idx[2:0];
        gid_i      = idx;
        found      = 1'b1;
      end
    end
  end

  // State is IDLE during reset too, so gate by reset to keep grants off then.
  assign req_ready = (state == S_IDLE && reset) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      cvt_rst_n    <= 1'b0;
      cvt_double   <= '0;
      cvt_rounding <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_float    <= '0;
      rsp_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cvt_rst_n <= 1'b1;
          if (accept) begin
            cvt_double   <= req_double[64*gid_i +: 64];
            cvt_rounding <= req_rounding[2*gid_i +: 2];
            rsp_id       <= gid;
            rr_ptr       <= (gid == 3'(NREQ-1)) ? 3'd0 : gid + 3'd1;
            cvt_rst_n    <= 1'b0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cvt_rst_n <= 1'b1;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // cnt == 0 marks the first WAIT cycle, where done may still be stale.
          if (cnt != 8'd0 && cvt_done) begin
            rsp_float <= cvt_float;
            rsp_flags <= {1'b0, cvt_unf, cvt_ovf, cvt_nan};
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == TO_LIMIT) begin
              rsp_float <= 32'h7FC0_0000;
              rsp_flags <= 4'b1000;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (sticky_clr)
        sticky_flags <= '0;
      else if (rsp_valid && rsp_ready)
        sticky_flags <= sticky_flags | rsp_flags;
    end
  end

endmodule

// File: tb/tb_fp_convert_arbiter.sv
// Directed bench for fp_convert_arbiter with a small converter model whose
// done behaviour is selectable (normal, never, stuck high).
module tb_fp_convert_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [64*NREQ-1:0]  req_double;
  logic [2*NREQ-1:0]   req_rounding;
  logic                cvt_rst_n;
  logic [63:0]         cvt_double;
  logic [1:0]          cvt_rounding;
  logic                cvt_done;
  logic [31:0]         m_float;
  logic                m_nan, m_ovf, m_unf;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2:0]          rsp_id;
  logic [31:0]         rsp_float;
  logic [3:0]          rsp_flags;
  logic [3:0]          sticky_flags;
  logic                sticky_clr;
  logic [1:0]          dbg_state;

  int tests_run = 0;
  int failures  = 0;
  int m_mode    = 0; // 0 normal, 1 never done, 2 done stuck high

  fp_convert_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_double(req_double), .req_rounding(req_rounding),
    .cvt_rst_n(cvt_rst_n), .cvt_double(cvt_double), .cvt_rounding(cvt_rounding),
    .cvt_done(cvt_done), .cvt_float(m_float),
    .cvt_nan(m_nan), .cvt_ovf(m_ovf), .cvt_unf(m_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_float(rsp_float), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // converter model: done one cycle after restart is released
  always @(posedge clk) begin
    case (m_mode)
      0:       cvt_done <= cvt_rst_n;
      1:       cvt_done <= 1'b0;
      default: cvt_done <= 1'b1;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // accept edge counts as 1; returns edges until rsp_valid seen (-1 if never)
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || cvt_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b cvt_rst_n=%b want 0000/0/0",
               req_ready, rsp_valid, cvt_rst_n);
    end
    tests_run++;
    if (rsp_float !== 32'h0 || rsp_flags !== 4'h0 || rsp_id !== 3'd0 ||
        sticky_flags !== 4'h0 || cvt_double !== 64'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: float=%h flags=%b id=%0d sticky=%b dbl=%h st=%0d want zeros",
               rsp_float, rsp_flags, rsp_id, sticky_flags, cvt_double, dbg_state);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (cvt_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_cvt_rst_n: got %b want 1", cvt_rst_n);
    end
  endtask

  task automatic test_round_robin;
    int lat;
    logic [3:0] exp_grant;
    for (int i = 0; i < NREQ; i++) req_double[64*i +: 64] = 64'h4000_0000_0000_0000 + 64'(i);
    m_mode = 0; m_float = 32'h4000_0000; {m_nan, m_ovf, m_unf} = 3'b000;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_grant = 4'b0001 << (k % 4);
      tests_run++;
      if (req_ready !== exp_grant) begin
        failures++;
        $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, exp_grant);
      end
      tick();
      tests_run++;
      if (cvt_rst_n !== 1'b0 || req_ready !== 4'b0 ||
          cvt_double !== 64'h4000_0000_0000_0000 + 64'(k % 4)) begin
        failures++;
        $display("FAIL rr_issue_%0d: rst_n=%b ready=%b dbl=%h want 0/0000/%h",
                 k, cvt_rst_n, req_ready, cvt_double, 64'h4000_0000_0000_0000 + 64'(k % 4));
      end
      wait_rsp(lat);
      tests_run++;
      if (lat !== 4 || rsp_id !== 3'(k % 4)) begin
        failures++;
        $display("FAIL rr_resp_%0d: lat=%0d id=%0d want 4/%0d", k, lat, rsp_id, k % 4);
      end
      tick(); // handshake; next grant must be visible right away
    end
    req_valid = 4'b0;
  endtask

  task automatic test_single;
    int lat;
    m_mode = 0; m_float = 32'h3F80_0000; {m_nan, m_ovf, m_unf} = 3'b000;
    req_double[63:0] = 64'h3FF0_0000_0000_0000;
    req_rounding[1:0] = 2'b00;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0;
    wait_rsp(lat);
    tests_run++;
    if (lat !== 4 || rsp_id !== 3'd0 || rsp_float !== 32'h3F80_0000 || rsp_flags !== 4'b0000) begin
      failures++;
      $display("FAIL single_resp: lat=%0d id=%0d float=%h flags=%b want 4/0/3f800000/0000",
               lat, rsp_id, rsp_float, rsp_flags);
    end
    tests_run++;
    if (cvt_double !== 64'h3FF0_0000_0000_0000 || cvt_rounding !== 2'b00) begin
      failures++;
      $display("FAIL single_cvt_inputs: dbl=%h rnd=%b want 3ff0000000000000/00", cvt_double, cvt_rounding);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0 || sticky_flags !== 4'b0000) begin
      failures++;
      $display("FAIL single_after: rsp_valid=%b sticky=%b want 0/0000", rsp_valid, sticky_flags);
    end
  endtask

  task automatic test_stale_done;
    int lat;
    m_mode = 2; m_float = 32'h4040_0000; {m_nan, m_ovf, m_unf} = 3'b000;
    req_double[127:64] = 64'h4008_0000_0000_0000;
    req_rounding[3:2] = 2'b11;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0;
    wait_rsp(lat);
    tests_run++;
    if (lat !== 4 || rsp_id !== 3'd1 || rsp_float !== 32'h4040_0000 || cvt_rounding !== 2'b11) begin
      failures++;
      $display("FAIL stale_done: lat=%0d id=%0d float=%h rnd=%b want 4/1/40400000/11",
               lat, rsp_id, rsp_float, cvt_rounding);
    end
    tick();
  endtask

  task automatic test_timeout;
    int lat;
    m_mode = 1; m_float = 32'h1234_5678; {m_nan, m_ovf, m_unf} = 3'b000;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = 4'b0;
    wait_rsp(lat);
    tests_run++;
    if (lat !== TIMEOUT + 2 || rsp_float !== 32'h7FC0_0000 || rsp_flags !== 4'b1000 || rsp_id !== 3'd2) begin
      failures++;
      $display("FAIL timeout_resp: lat=%0d float=%h flags=%b id=%0d want %0d/7fc00000/1000/2",
               lat, rsp_float, rsp_flags, rsp_id, TIMEOUT + 2);
    end
    tick();
    tests_run++;
    if (sticky_flags !== 4'b1000) begin
      failures++;
      $display("FAIL timeout_sticky: got %b want 1000", sticky_flags);
    end
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests_run++;
    if (sticky_flags !== 4'b0000) begin
      failures++;
      $display("FAIL sticky_clr_idle: got %b want 0000", sticky_flags);
    end
    m_mode = 0;
  endtask

  task automatic test_overflow_hold;
    int lat;
    m_mode = 0; m_float = 32'h7F80_0000; {m_nan, m_ovf, m_unf} = 3'b010;
    req_double[191:128] = 64'h47F0_0000_0000_0000;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = 4'b0001; // competing request must not be granted mid-flight
    wait_rsp(lat);
    tests_run++;
    if (lat !== 4 || rsp_flags !== 4'b0010 || rsp_float !== 32'h7F80_0000) begin
      failures++;
      $display("FAIL ovf_resp: lat=%0d flags=%b float=%h want 4/0010/7f800000", lat, rsp_flags, rsp_float);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_flags !== 4'b0010 || rsp_float !== 32'h7F80_0000 ||
          rsp_id !== 3'd2 || req_ready !== 4'b0) begin
        failures++;
        $display("FAIL ovf_hold_%0d: valid=%b flags=%b float=%h id=%0d ready=%b want 1/0010/7f800000/2/0000",
                 c, rsp_valid, rsp_flags, rsp_float, rsp_id, req_ready);
      end
    end
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0 || sticky_flags !== 4'b0010) begin
      failures++;
      $display("FAIL ovf_handshake: valid=%b sticky=%b want 0/0010", rsp_valid, sticky_flags);
    end
  endtask

  task automatic test_sticky_clr_nan;
    int lat;
    m_mode = 0; m_float = 32'h7FC0_0001; {m_nan, m_ovf, m_unf} = 3'b100;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = 4'b0;
    wait_rsp(lat);
    tests_run++;
    if (lat !== 4 || rsp_flags !== 4'b0001 || rsp_id !== 3'd3) begin
      failures++;
      $display("FAIL nan_resp: lat=%0d flags=%b id=%0d want 4/0001/3", lat, rsp_flags, rsp_id);
    end
    rsp_ready = 1'b1;
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests_run++;
    if (sticky_flags !== 4'b0000 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL nan_sticky_clr: sticky=%b valid=%b want 0000/0", sticky_flags, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    m_mode = 1; {m_nan, m_ovf, m_unf} = 3'b000;
    req_double[127:64] = 64'hC000_0000_0000_0000;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0;
    tick();
    tick();
    tests_run++;
    if (dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL midwait_state: got %0d want 2", dbg_state);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || cvt_rst_n !== 1'b0 || cvt_double !== 64'h0 ||
        req_ready !== 4'b0 || dbg_state !== 2'd0 || sticky_flags !== 4'b0) begin
      failures++;
      $display("FAIL midwait_async_reset: valid=%b rst_n=%b dbl=%h ready=%b st=%0d sticky=%b want zeros/idle",
               rsp_valid, cvt_rst_n, cvt_double, req_ready, dbg_state, sticky_flags);
    end
    tick();
    reset = 1'b1;
    m_mode = 0; m_float = 32'h3F80_0000;
    lat = 0;
    for (int c = 0; c < TIMEOUT + 4; c++) begin
      tick();
      if (rsp_valid) lat++;
    end
    tests_run++;
    if (lat !== 0) begin
      failures++;
      $display("FAIL midwait_discard: rsp_valid seen %0d cycles want 0", lat);
    end
    req_valid = 4'b1111;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midwait_rr_ptr: grant=%b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0;
    wait_rsp(lat);
    tests_run++;
    if (lat !== 4 || rsp_id !== 3'd0 || rsp_float !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL midwait_next_req: lat=%0d id=%0d float=%h want 4/0/3f800000", lat, rsp_id, rsp_float);
    end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_double = '0;
    req_rounding = '0;
    rsp_ready = 1'b0;
    sticky_clr = 1'b0;
    m_float = '0;
    m_nan = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_stale_done();
    test_timeout();
    test_overflow_hold();
    test_sticky_clr_nan();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/fp_convert_arbiter.md
FP_CONVERT_ARBITER -- requirements
Module: fp_convert_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one double-to-float converter (2..8).
REQ-002 Parameter TIMEOUT, default 15, max cycles to wait for converter done before abort (1..255).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester conversion request.
REQ-006 req_ready  output  NREQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
REQ-007 req_double  input  64*NREQ  operand of requester i at bits [64i+63:64i].
REQ-008 req_rounding  input  2*NREQ  rounding mode of requester i at bits [2i+1:2i] (00 zero, 01 +inf, 10 -inf, 11 nearest).
REQ-009 cvt_rst_n  output  1  active-low restart to converter.
REQ-010 cvt_double  output  64  operand to converter; cvt_rounding  output  2  rounding to converter.
REQ-011 cvt_done, cvt_float[31:0], cvt_nan, cvt_ovf, cvt_unf  input  converter results.
REQ-012 rsp_valid  output  1; rsp_ready  input  1; response handshake.
REQ-013 rsp_id  output  3  index of requester owning response; rsp_float  output  32  result.
REQ-014 rsp_flags  output  4  {timeout, unf, ovf, nan} for this response.
REQ-015 sticky_flags  output  4  OR-accumulated rsp_flags; sticky_clr  input  1  clears them.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: req_ready SHALL be one-hot on the first valid requester at or after rr_ptr (wrapping modulo NREQ), zero if none valid; grant is combinational from req_valid and rr_ptr.
REQ-018 On acceptance, operand, rounding and id SHALL be captured into internal registers; rr_ptr <= granted id + 1 modulo NREQ; next state ISSUE.
REQ-019 req_ready SHALL be all-zero in ISSUE, WAIT, RESP (one conversion in flight).
REQ-020 cvt_double/cvt_rounding SHALL drive the captured registers, stable from ISSUE through RESP.
REQ-021 ISSUE: cvt_rst_n SHALL be 0 for exactly one cycle; state -> WAIT; timeout counter cleared to 0.
REQ-022 WAIT: cvt_rst_n = 1; cvt_done sampled high SHALL capture cvt_float and {0, cvt_unf, cvt_ovf, cvt_nan} -> RESP.
REQ-023 WAIT: counter increments each cycle without done; on reaching TIMEOUT, capture float 32'h7FC00000 and flags 4'b1000 -> RESP.
REQ-024 cvt_done in the first WAIT cycle SHALL be ignored (stale value from before restart); counter still increments.
REQ-025 RESP: rsp_valid = 1; rsp_id/rsp_float/rsp_flags held stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-026 rsp_valid SHALL be 0 in all other states.
REQ-027 sticky_flags SHALL OR in rsp_flags on the response handshake cycle; sticky_clr takes priority over a simultaneous OR-in (result 0).
REQ-028 Minimum latency accept -> rsp_valid SHALL be 4 cycles (accept, ISSUE, WAIT x1 ignored, done sampled, RESP).
REQ-029 Back-to-back: after a RESP handshake, a new grant SHALL be possible in the next cycle (IDLE).
REQ-030 Deasserting req_valid[i] without a grant SHALL have no effect; no request is lost once accepted.

Reset
REQ-031 reset low SHALL asynchronously force: state IDLE, rr_ptr 0, counter 0, cvt_rst_n 0, rsp_valid 0, req_ready 0, rsp_id 0, rsp_float 0, rsp_flags 0, sticky_flags 0, captured operand 0.
REQ-032 cvt_rst_n SHALL stay 0 while reset is low and return to 1 on the first clock edge after release in IDLE.
REQ-033 Reset during WAIT or RESP SHALL discard the in-flight conversion with no response.

Verification
REQ-034 Single req: req_valid=0001, operand 64'h3FF0000000000000, rounding 00 -> rsp_id 0, rsp_float 32'h3F800000, flags 0, rsp_valid 4 cycles after accept.
REQ-035 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no requester starved.
REQ-036 Converter model never asserts done -> after TIMEOUT WAIT cycles rsp_float 32'h7FC00000, rsp_flags 4'b1000, sticky bit3 set.
REQ-037 Operand 64'h47F0000000000000 (overflow) -> rsp_flags 4'b0010; rsp_ready held 0 for 5 cycles -> outputs stable, no new grant.
REQ-038 sticky_clr asserted on same cycle as nan response handshake -> sticky_flags 0 next cycle.
REQ-039 reset pulsed low mid-WAIT -> all outputs at reset values immediately; next request serviced normally from rr_ptr 0.
